adc_serial_reg_slave: RTL and testbench

- Responder end of the ADC 3-wire serial register-write interface (sen active-low, sclk idle-high, sdata MSB-first, 8-bit address then 8-bit data).
- Oversamples the bus on clk, decodes 16-bit frames, and updates a 4-entry register shadow (0x00, 0x3D, 0x41, 0x25). Honours the ADC hardware reset pin.
- Used as the ADC-side bus model in system benches and as an on-board configuration mirror.

---
 rtl/adc_serial_reg_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_adc_serial_reg_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_reg_slave.sv
// adc_serial_reg_slave
// Responder end of the ADC 3-wire serial register-write bus (sen active-low,
// sclk idle-high, sdata MSB-first, 8-bit address then 8-bit data).
// The bus is oversampled on clk. Each valid 16-bit frame updates a 4-entry
// register shadow (0x00, 0x3D, 0x41, 0x25). The ADC hardware reset pin
// (adc_reset) returns the shadow to its defaults and aborts any frame in flight.
// Optional build macro ADC_SERIAL_REG_SLAVE_ERR_CNT_EN adds a saturating
// error counter output (err_cnt) that counts frame_err and addr_miss pulses.

module adc_serial_reg_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEF_00      = 8'h00,
    parameter logic [7:0]  DEF_3D      = 8'h00,
    parameter logic [7:0]  DEF_41      = 8'h00,
    parameter logic [7:0]  DEF_25      = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sen,
    input  logic       sclk,
    input  logic       sdata,
    input  logic       adc_reset,
    output logic [7:0] reg_00,
    output logic [7:0] reg_3d,
    output logic [7:0] reg_41,
    output logic [7:0] reg_25,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       addr_miss,
    output logic       frame_err,
    output logic       init_done
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    // Depths below two are not metastability-safe; clamp instead of failing.
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge-detect history
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] sen_sync_q;
    logic [SYNC_N-1:0] sclk_sync_q;
    logic [SYNC_N-1:0] sdata_sync_q;
    logic [SYNC_N-1:0] arst_sync_q;
    logic              sen_prev_q;
    logic              sclk_prev_q;

    logic              sen_s;
    logic              sclk_s;
    logic              sdata_s;
    logic              arst_s;
    logic              sen_fall;
    logic              sen_rise;
    logic              sclk_fall;

    // Synchronize the asynchronous bus pins and keep one extra flop for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sen_sync_q   <= '1;
            sclk_sync_q  <= '1;
            sdata_sync_q <= '1;
            arst_sync_q  <= '0;
            sen_prev_q   <= 1'b1;
            sclk_prev_q  <= 1'b1;
        end else begin
            sen_sync_q   <= {sen_sync_q[SYNC_N-2:0], sen};
            sclk_sync_q  <= {sclk_sync_q[SYNC_N-2:0], sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_N-2:0], sdata};
            arst_sync_q  <= {arst_sync_q[SYNC_N-2:0], adc_reset};
            sen_prev_q   <= sen_sync_q[SYNC_N-1];
            sclk_prev_q  <= sclk_sync_q[SYNC_N-1];
        end
    end

    assign sen_s     = sen_sync_q[SYNC_N-1];
    assign sclk_s    = sclk_sync_q[SYNC_N-1];
    assign sdata_s   = sdata_sync_q[SYNC_N-1];
    assign arst_s    = arst_sync_q[SYNC_N-1];
    assign sen_fall  = sen_prev_q & ~sen_s;
    assign sen_rise  = ~sen_prev_q & sen_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // ------------------------------------------------------------------
    // Frame state, shift register and register shadow
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [15:0] sr_q;
    logic [15:0] sr_d;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic [7:0]  reg00_q;
    logic [7:0]  reg3d_q;
    logic [7:0]  reg41_q;
    logic [7:0]  reg25_q;
    logic [3:0]  mask_q;
    logic [3:0]  sel;
    logic        wr_strobe_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        addr_miss_q;
    logic        frame_err_q;
    logic        init_done_q;
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
    logic [7:0]  err_cnt_q;
`endif

    // Next shift-register/bit-count value for a sclk falling edge inside a frame
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if ((state_q == ST_SHIFT) && sclk_fall) begin
            sr_d = {sr_q[14:0], sdata_s};
            if (cnt_q != 5'd17) begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    // One-hot select of the shadow register addressed by the captured frame
    always_comb begin
        sel = 4'b0000;
        case (sr_q[15:8])
            8'h00:   sel = 4'b0001;
            8'h3D:   sel = 4'b0010;
            8'h41:   sel = 4'b0100;
            8'h25:   sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
    end

    // Frame FSM with registered strobes, shadow registers and written-mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            reg00_q     <= DEF_00;
            reg3d_q     <= DEF_3D;
            reg41_q     <= DEF_41;
            reg25_q     <= DEF_25;
            mask_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            addr_miss_q <= 1'b0;
            frame_err_q <= 1'b0;
            init_done_q <= 1'b0;
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            wr_strobe_q <= 1'b0;
            addr_miss_q <= 1'b0;
            frame_err_q <= 1'b0;
            init_done_q <= &mask_q;
            if (arst_s) begin
                // Hardware reset wins over everything, including a pending commit.
                state_q     <= ST_IDLE;
                sr_q        <= '0;
                cnt_q       <= '0;
                reg00_q     <= DEF_00;
                reg3d_q     <= DEF_3D;
                reg41_q     <= DEF_41;
                reg25_q     <= DEF_25;
                mask_q      <= '0;
                init_done_q <= 1'b0;
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
                err_cnt_q   <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sen_fall) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        // A bit arriving with sen rising is shifted before the commit count check.
                        sr_q  <= sr_d;
                        cnt_q <= cnt_d;
                        if (sen_rise) begin
                            state_q <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        state_q <= ST_IDLE;
                        if (cnt_q == 5'd16) begin
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= sr_q[15:8];
                            wr_data_q   <= sr_q[7:0];
                            if (sel == 4'b0000) begin
                                addr_miss_q <= 1'b1;
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
                                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
                            end else begin
                                if (sel[0]) reg00_q <= sr_q[7:0];
                                if (sel[1]) reg3d_q <= sr_q[7:0];
                                if (sel[2]) reg41_q <= sr_q[7:0];
                                if (sel[3]) reg25_q <= sr_q[7:0];
                                mask_q <= mask_q | sel;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign reg_00    = reg00_q;
    assign reg_3d    = reg3d_q;
    assign reg_41    = reg41_q;
    assign reg_25    = reg25_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign addr_miss = addr_miss_q;
    assign frame_err = frame_err_q;
    assign init_done = init_done_q;
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_adc_serial_reg_slave.sv
// Testbench for adc_serial_reg_slave: directed frames from the test plan plus
// randomized frames, checked against a register-map model of the responder.

module tb_adc_serial_reg_slave;

    localparam int unsigned SYNC   = 2;
    localparam logic [7:0]  D00    = 8'h11;
    localparam logic [7:0]  D3D    = 8'h22;
    localparam logic [7:0]  D41    = 8'h33;
    localparam logic [7:0]  D25    = 8'h44;
    localparam logic [7:0]  MAP_ADDR [4] = '{8'h00, 8'h3D, 8'h41, 8'h25};
    localparam logic [7:0]  MAP_DEF  [4] = '{D00, D3D, D41, D25};

    logic       clk = 1'b0;
    logic       rst_n, sen, sclk, sdata, adc_reset;
    logic [7:0] reg_00, reg_3d, reg_41, reg_25, wr_addr, wr_data;
    logic       wr_strobe, addr_miss, frame_err, init_done;
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    adc_serial_reg_slave #(
        .SYNC_STAGES(SYNC),
        .DEF_00(D00),
        .DEF_3D(D3D),
        .DEF_41(D41),
        .DEF_25(D25)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sen(sen),
        .sclk(sclk),
        .sdata(sdata),
        .adc_reset(adc_reset),
        .reg_00(reg_00),
        .reg_3d(reg_3d),
        .reg_41(reg_41),
        .reg_25(reg_25),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .addr_miss(addr_miss),
        .frame_err(frame_err),
        .init_done(init_done)
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    // 20 MHz system clock
    always #25 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed pulse counts
    int obs_strobe = 0;
    int obs_miss   = 0;
    int obs_ferr   = 0;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) obs_strobe++;
        if (addr_miss === 1'b1) obs_miss++;
        if (frame_err === 1'b1) obs_ferr++;
    end

    // Reference model: register map, written set and expected pulse counts
    logic [7:0] exp_reg [4];
    bit         written [4];
    logic [7:0] exp_addr, exp_data;
    int         exp_strobe = 0;
    int         exp_miss   = 0;
    int         exp_ferr   = 0;
    int         exp_errcnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int map_idx(input logic [7:0] a);
        for (int i = 0; i < 4; i++) if (MAP_ADDR[i] == a) return i;
        return -1;
    endfunction

    function automatic void model_defaults();
        for (int i = 0; i < 4; i++) begin
            exp_reg[i] = MAP_DEF[i];
            written[i] = 1'b0;
        end
        exp_errcnt = 0;
    endfunction

    function automatic void model_frame(input int nbits, input logic [31:0] bits);
        int idx;
        if (nbits == 16) begin
            exp_strobe++;
            exp_addr = bits[15:8];
            exp_data = bits[7:0];
            idx = map_idx(bits[15:8]);
            if (idx < 0) begin
                exp_miss++;
                if (exp_errcnt < 255) exp_errcnt++;
            end else begin
                exp_reg[idx] = bits[7:0];
                written[idx] = 1'b1;
            end
        end else begin
            exp_ferr++;
            if (exp_errcnt < 255) exp_errcnt++;
        end
    endfunction

    function automatic logic exp_init();
        return written[0] && written[1] && written[2] && written[3];
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ":strobes"}, obs_strobe, exp_strobe);
        check_eq({tag, ":misses"}, obs_miss, exp_miss);
        check_eq({tag, ":ferrs"}, obs_ferr, exp_ferr);
        check_eq({tag, ":wr_addr"}, wr_addr, exp_addr);
        check_eq({tag, ":wr_data"}, wr_data, exp_data);
        check_eq({tag, ":reg_00"}, reg_00, exp_reg[0]);
        check_eq({tag, ":reg_3d"}, reg_3d, exp_reg[1]);
        check_eq({tag, ":reg_41"}, reg_41, exp_reg[2]);
        check_eq({tag, ":reg_25"}, reg_25, exp_reg[3]);
        check_eq({tag, ":init_done"}, init_done, exp_init());
`ifdef ADC_SERIAL_REG_SLAVE_ERR_CNT_EN
        check_eq({tag, ":err_cnt"}, err_cnt, exp_errcnt);
`endif
    endtask

    // Drive a frame of nbits (MSB first from bits[nbits-1]); half = clk per sclk phase.
    // tight: the final sclk fall coincides with sen rising.
    task automatic send_frame(input int nbits, input logic [31:0] bits, input int half,
                              input bit do_start, input bit do_end, input bit tight);
        if (do_start) begin
            @(negedge clk);
            sen = 1'b0;
            repeat (half) @(negedge clk);
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            sdata = bits[i];
            repeat (half) @(negedge clk);
            if (i == 0 && tight && do_end) begin
                sclk = 1'b0;
                sen  = 1'b1;
                repeat (half) @(negedge clk);
                sclk = 1'b1;
                return;
            end
            sclk = 1'b0;
            repeat (half) @(negedge clk);
            sclk = 1'b1;
        end
        if (do_end) begin
            repeat (half) @(negedge clk);
            sen = 1'b1;
        end
    endtask

    task automatic settle_check(input string tag);
        repeat (12) @(negedge clk);
        check_state(tag);
    endtask

    task automatic frame_and_check(input string tag, input int nbits, input logic [31:0] bits,
                                   input int half, input bit tight);
        send_frame(nbits, bits, half, 1'b1, 1'b1, tight);
        model_frame(nbits, bits);
        settle_check(tag);
    endtask

    initial begin
        int k;
        int nb, half;
        logic [31:0] bits;

        rst_n = 1'b0; sen = 1'b1; sclk = 1'b1; sdata = 1'b1; adc_reset = 1'b0;
        model_defaults();
        exp_addr = 8'h00;
        exp_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_state("reset");

        // First frame at 64 clk/bit, with strobe latency measured from raw sen rising
        send_frame(16, 32'h0002, 32, 1'b1, 1'b1, 1'b0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (wr_strobe === 1'b1) begin
                k = i;
                break;
            end
        end
        check_eq("latency", k, SYNC + 2);
        model_frame(16, 32'h0002);
        settle_check("f00_02");

        frame_and_check("f3d_e0", 16, 32'h3DE0, 32, 1'b0);
        frame_and_check("f41_c0", 16, 32'h41C0, 32, 1'b0);
        frame_and_check("f25_03", 16, 32'h2503, 32, 1'b0);

        // Bit-count errors
        frame_and_check("f15bit", 15, 32'h4155, 8, 1'b0);
        frame_and_check("f17bit", 17, 32'h1_3D77, 8, 1'b0);
        frame_and_check("f0bit", 0, 32'h0, 8, 1'b0);

        // Unmapped address
        frame_and_check("f10_aa", 16, 32'h10AA, 8, 1'b0);

        // Last-bit sclk fall together with sen rise
        frame_and_check("tight", 16, 32'h00C3, 8, 1'b1);

        // adc_reset pulse in the middle of a frame
        send_frame(8, 32'h41, 8, 1'b1, 1'b0, 1'b0);
        adc_reset = 1'b1;
        repeat (10) @(negedge clk);
        adc_reset = 1'b0;
        model_defaults();
        repeat (6) @(negedge clk);
        sen = 1'b1;
        settle_check("adc_rst_abort");

        // sen falling while adc_reset held: the frame must not be captured
        adc_reset = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(0, 32'h0, 8, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        adc_reset = 1'b0;
        repeat (6) @(negedge clk);
        send_frame(16, 32'h3D99, 8, 1'b0, 1'b1, 1'b0);
        settle_check("adc_rst_held");

        frame_and_check("post_arst", 16, 32'h41C0, 32, 1'b0);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            bits = $urandom;
            half = $urandom_range(4, 12);
            nb = ($urandom_range(0, 9) < 7) ? 16 : $urandom_range(0, 20);
            if (nb == 16 && $urandom_range(0, 3) != 0) bits[15:8] = MAP_ADDR[$urandom_range(0, 3)];
            frame_and_check("rand", nb, bits, half, $urandom_range(0, 3) == 0);
        end

        // rst_n asserted mid-frame
        send_frame(8, 32'h25, 8, 1'b1, 1'b0, 1'b0);
        #7;
        rst_n = 1'b0;
        #1;
        model_defaults();
        exp_addr = 8'h00;
        exp_data = 8'h00;
        check_eq("rst:reg_00", reg_00, exp_reg[0]);
        check_eq("rst:reg_3d", reg_3d, exp_reg[1]);
        check_eq("rst:reg_41", reg_41, exp_reg[2]);
        check_eq("rst:reg_25", reg_25, exp_reg[3]);
        check_eq("rst:wr_addr", wr_addr, exp_addr);
        check_eq("rst:wr_data", wr_data, exp_data);
        check_eq("rst:init_done", init_done, 1'b0);
        check_eq("rst:pulses", {wr_strobe, addr_miss, frame_err}, 3'b000);
        sen = 1'b1;
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        frame_and_check("after_rst", 16, 32'h2503, 8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
